// File: rtl/m_xfer1_pkg.sv
// Shared types and helpers for the DMA channel-1 module-side transfer engine.
// Optional length check is enabled by defining M_XFER1_LENCHK_EN.
package m_xfer1_pkg;

  localparam int DW_DEF = 64;
  localparam int CW_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Byte 0 of the result is byte 7 of the input, and so on.
  function automatic logic [63:0] bswap64(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
    return r;
  endfunction

endpackage

// File: rtl/m_xfer1_hold.sv
// Single-entry holding register between the source pop and the destination push.
// A load wins over a drain on the same edge: the old word leaves, the new one stays.
module m_xfer1_hold
  import m_xfer1_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_last,
  input  logic          i_drain,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_last
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/m_xfer1.sv
// DMA channel-1 module-side engine: drains the source FIFO, optionally byte-swaps,
// fills the destination FIFO and signals end of job. Length check under M_XFER1_LENCHK_EN.
module m_xfer1
  import m_xfer1_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          job_start,
  input  logic          job_bswap,
  input  logic [CW-1:0] dc1,
  output logic          job_busy,
  output logic          job_done,
  output logic          job_err,
  output logic [CW-1:0] job_words,
  output logic          m_reset1,
  output logic          m_src_getn1,
  input  logic [DW-1:0] m_src1,
  input  logic          m_src_last1,
  input  logic          m_src_empty1,
  input  logic          m_src_almost_empty1,
  output logic          m_dst_putn1,
  output logic [DW-1:0] m_dst1,
  output logic          m_dst_last1,
  input  logic          m_dst_full1,
  input  logic          m_dst_almost_full1,
  output logic          m_endn1,
  output logic [2:0]    dbg_state
);

  // Handshakes: getn low for one cycle pops the source head, captured on the edge
  // ending that cycle; putn low for one cycle pushes m_dst1/m_dst_last1, and is only
  // raised from a holding word when m_dst_full1 was low on the deciding edge.
  state_t        r_state;
  logic          r_getn, r_putn, r_endn, r_reset;
  logic          r_busy, r_done, r_err, r_bswap;
  logic          r_seen, r_last_popped;
  logic [CW-1:0] r_words;
  logic [DW-1:0] r_dst;
  logic          r_dst_last;

  logic          w_hold_valid, w_hold_last;
  logic [DW-1:0] w_hold_data, w_src_word;
  logic          w_load, w_drain, w_clear, w_pop_ok;

  assign w_load     = !r_getn;
  assign w_src_word = r_bswap ? bswap64(m_src1) : m_src1;
  assign w_drain    = (r_state == ST_RUN) && w_hold_valid && !m_dst_full1;
  assign w_clear    = (r_state == ST_IDLE) && job_start;
  // r_seen means the head was already present last cycle, so its data has settled.
  assign w_pop_ok   = (r_state == ST_RUN) && r_getn && !m_src_empty1 && r_seen &&
                      !r_last_popped && (!w_hold_valid || w_drain);

  m_xfer1_hold #(.DW(DW)) u_hold (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_i),
    .i_clear (w_clear),
    .i_load  (w_load),
    .i_data  (w_src_word),
    .i_last  (m_src_last1),
    .i_drain (w_drain),
    .o_valid (w_hold_valid),
    .o_data  (w_hold_data),
    .o_last  (w_hold_last)
  );

`ifdef M_XFER1_LENCHK_EN
  logic [CW-1:0] r_dc;
  logic [CW:0]   w_exp_words;
  logic          w_unused_ok;
  // A zero byte count stands for 2^CW bytes.
  assign w_exp_words = (r_dc == '0) ? ({1'b1, {CW{1'b0}}} >> 3)
                                    : (({1'b0, r_dc} + (CW+1)'(7)) >> 3);
  assign w_unused_ok = ^{m_src_almost_empty1, m_dst_almost_full1};
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{dc1, m_src_almost_empty1, m_dst_almost_full1};
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state       <= ST_IDLE;
      r_getn        <= 1'b1;
      r_putn        <= 1'b1;
      r_endn        <= 1'b1;
      r_reset       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_bswap       <= 1'b0;
      r_seen        <= 1'b0;
      r_last_popped <= 1'b0;
      r_words       <= '0;
      r_dst         <= '0;
      r_dst_last    <= 1'b0;
`ifdef M_XFER1_LENCHK_EN
      r_dc          <= '0;
`endif
    end else begin
      r_getn  <= 1'b1;
      r_putn  <= 1'b1;
      r_reset <= 1'b0;
      r_done  <= 1'b0;
      r_seen  <= (r_state == ST_RUN) && !m_src_empty1;
      if (w_pop_ok) r_getn <= 1'b0;
      if (w_load && m_src_last1) r_last_popped <= 1'b1;
      if (!r_putn) r_words <= r_words + CW'(1);
      if (w_drain) begin
        r_putn     <= 1'b0;
        r_dst      <= w_hold_data;
        r_dst_last <= w_hold_last;
      end
      case (r_state)
        ST_IDLE: if (job_start) begin
          r_state       <= ST_CLR;
          r_reset       <= 1'b1;
          r_busy        <= 1'b1;
          r_bswap       <= job_bswap;
          r_words       <= '0;
          r_err         <= 1'b0;
          r_last_popped <= 1'b0;
          r_dst_last    <= 1'b0;
`ifdef M_XFER1_LENCHK_EN
          r_dc          <= dc1;
`endif
        end
        ST_CLR: r_state <= ST_RUN;
        ST_RUN: if (!r_putn && r_dst_last) begin
          r_state <= ST_FLUSH;
          r_endn  <= 1'b0;
        end
        ST_FLUSH: begin
          r_state <= ST_DONE;
          r_endn  <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
`ifdef M_XFER1_LENCHK_EN
          r_err   <= ({1'b0, r_words} != w_exp_words);
`endif
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign job_busy    = r_busy;
  assign job_done    = r_done;
  assign job_err     = r_err;
  assign job_words   = r_words;
  assign m_reset1    = r_reset;
  assign m_src_getn1 = r_getn;
  assign m_dst_putn1 = r_putn;
  assign m_dst1      = r_dst;
  assign m_dst_last1 = r_dst_last;
  assign m_endn1     = r_endn;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_m_xfer1.sv
// Bench for m_xfer1: source FIFO model, destination capture, per-job scoreboard.
// Expected job_err follows M_XFER1_LENCHK_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_m_xfer1;
  import m_xfer1_pkg::*;

  localparam int DW = 64;
  localparam int CW = 24;
  localparam int W  = DW + 1;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b0;
  logic          job_start = 1'b0;
  logic          job_bswap = 1'b0;
  logic [CW-1:0] dc1 = '0;
  logic          job_busy, job_done, job_err;
  logic [CW-1:0] job_words;
  logic          m_reset1, m_src_getn1;
  logic [DW-1:0] m_src1 = '0;
  logic          m_src_last1 = 1'b0;
  logic          m_src_empty1 = 1'b1;
  logic          m_dst_putn1, m_dst_last1, m_endn1;
  logic [DW-1:0] m_dst1;
  logic          m_dst_full1;
  logic [2:0]    dbg_state;
  logic          full_dir = 1'b0;
  logic          full_rnd = 1'b0;
  logic          rand_full = 1'b0;

  assign m_dst_full1 = full_dir | full_rnd;

  m_xfer1 dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .job_start(job_start), .job_bswap(job_bswap),
    .dc1(dc1), .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
    .job_words(job_words), .m_reset1(m_reset1), .m_src_getn1(m_src_getn1), .m_src1(m_src1),
    .m_src_last1(m_src_last1), .m_src_empty1(m_src_empty1), .m_src_almost_empty1(1'b0),
    .m_dst_putn1(m_dst_putn1), .m_dst1(m_dst1), .m_dst_last1(m_dst_last1),
    .m_dst_full1(m_dst_full1), .m_dst_almost_full1(1'b0), .m_endn1(m_endn1),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- source FIFO model ----------------
  logic [W-1:0] src_q[$];
  int           src_rd = 0;
  logic         pop_pend = 1'b0;
  logic         clr_pend = 1'b0;

  always @(negedge wb_clk_i) begin
    pop_pend = wb_rst_i && !m_src_getn1;
    clr_pend = wb_rst_i && m_reset1;
  end

  always @(posedge wb_clk_i) begin
    #1;
    if (clr_pend) src_rd = src_q.size();
    else if (pop_pend) src_rd++;
    if (src_rd < src_q.size()) begin
      m_src1       = src_q[src_rd][DW-1:0];
      m_src_last1  = src_q[src_rd][DW];
      m_src_empty1 = 1'b0;
    end else begin
      m_src1       = '0;
      m_src_last1  = 1'b0;
      m_src_empty1 = 1'b1;
    end
  end

  always @(negedge wb_clk_i) full_rnd = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;

  // ---------------- destination capture / protocol monitor ----------------
  logic [W-1:0] rx_q[$];
  int   cyc = 0, last_get = -10, empty_run = 0, endn_cnt = 0, done_cnt = 0;
  logic full_at_edge = 1'b0;

  always @(posedge wb_clk_i) full_at_edge <= m_dst_full1;

  always @(negedge wb_clk_i) begin
    cyc++;
    empty_run = m_src_empty1 ? 0 : empty_run + 1;
    if (wb_rst_i) begin
      if (!m_src_getn1) begin
        chk("pop_not_empty", m_src_empty1, 1'b0);
        chk("pop_gap", (cyc - last_get) >= 2, 1'b1);
        chk("pop_settle", empty_run >= 2, 1'b1);
        last_get = cyc;
      end
      if (!m_dst_putn1) begin
        chk("push_while_full", full_at_edge, 1'b0);
        rx_q.push_back({m_dst_last1, m_dst1});
      end
      if (!m_endn1) endn_cnt++;
      if (job_done) done_cnt++;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  bit            cur_bs;
  logic [CW-1:0] job_dc;
  int            rx_base, endn_base;

  function automatic logic exp_err(input int n, input logic [CW-1:0] dc);
`ifdef M_XFER1_LENCHK_EN
    longint bytes;
    bytes = (dc == '0) ? 64'd16777216 : longint'(dc);
    return longint'(n) != (bytes + 7) / 8;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(negedge wb_clk_i);
    #1;
  endtask

  task automatic add_word(input logic [DW-1:0] w, input logic last);
    logic [DW-1:0] sw;
    sw = {<<8{w}};
    src_q.push_back({last, w});
    exp_q.push_back({last, cur_bs ? sw : w});
  endtask

  task automatic add_random(input int n, input bit ends);
    for (int i = 0; i < n; i++) add_word({$urandom, $urandom}, ends && (i == n - 1));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_getn"}, m_src_getn1, 1'b1);
    chk({tag, "_putn"}, m_dst_putn1, 1'b1);
    chk({tag, "_endn"}, m_endn1, 1'b1);
    chk({tag, "_mreset"}, m_reset1, 1'b0);
    chk({tag, "_busy"}, job_busy, 1'b0);
    chk({tag, "_done"}, job_done, 1'b0);
    chk({tag, "_err"}, job_err, 1'b0);
    chk({tag, "_words"}, job_words, '0);
    chk({tag, "_dst"}, {m_dst_last1, m_dst1}, '0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  task automatic start_job(input bit bs, input logic [CW-1:0] dc);
    cur_bs    = bs;
    job_dc    = dc;
    exp_q.delete();
    rx_base   = rx_q.size();
    endn_base = endn_cnt;
    job_start = 1'b1;
    job_bswap = bs;
    dc1       = dc;
    tick();
    job_start = 1'b0;
    job_bswap = 1'($urandom_range(0, 1));
    dc1       = CW'($urandom);
    chk("clr_pulse", m_reset1, 1'b1);
    chk("busy_at_start", job_busy, 1'b1);
    chk("words_cleared", job_words, '0);
    tick();
    chk("clr_one_cycle", m_reset1, 1'b0);
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while ((rx_q.size() - rx_base) < n && t < 2000) begin tick(); t++; end
    chk("wait_rx", (rx_q.size() - rx_base) >= n, 1'b1);
  endtask

  task automatic finish_job(input int n);
    int t = 0;
    while (!job_done && t < 3000) begin tick(); t++; end
    chk("done_seen", job_done, 1'b1);
    chk("job_words", job_words, n);
    chk("job_err", job_err, exp_err(n, job_dc));
    chk("busy_low_at_done", job_busy, 1'b0);
    chk("endn_cycles", endn_cnt - endn_base, 1);
    chk("rx_count", rx_q.size() - rx_base, n);
    for (int i = 0; i < n && i < exp_q.size() && (rx_base + i) < rx_q.size(); i++)
      chk($sformatf("rx_word%0d", i), rx_q[rx_base + i], exp_q[i]);
    tick();
    chk("done_one_cycle", job_done, 1'b0);
    chk("idle_after", dbg_state, ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, n0, db;
    bit bs;
    logic [DW-1:0] got;

    repeat (3) tick();
    check_reset_vals("reset");
    wb_rst_i = 1'b1;
    tick();

    // 4 plain words, last on the fourth
    start_job(1'b0, 24'd32);
    for (int i = 0; i < 4; i++) add_word(64'h0011223344556677 + 64'(i), i == 3);
    finish_job(4);

    // byte swap of a known word
    start_job(1'b1, 24'd8);
    add_word(64'h0102030405060708, 1'b1);
    finish_job(1);
    got = rx_q[rx_q.size() - 1][DW-1:0];
    chk("bswap_literal", got, 64'h0807060504030201);

    // destination full for 10 cycles after the first push
    start_job(1'($urandom_range(0, 1)), 24'd64);
    add_random(8, 1'b1);
    wait_rx(1);
    full_dir = 1'b1;
    tick();
    n0 = rx_q.size();
    repeat (9) tick();
    chk("no_push_while_full", rx_q.size(), n0);
    full_dir = 1'b0;
    finish_job(8);

    // source runs dry for a while mid-job
    start_job(1'b0, 24'd48);
    add_random(3, 1'b0);
    wait_rx(3);
    repeat (5) tick();
    add_random(3, 1'b1);
    finish_job(6);

    // random jobs with random backpressure and an ignored restart pulse
    rand_full = 1'b1;
    for (int j = 0; j < 6; j++) begin
      bs = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 12);
      start_job(bs, ($urandom_range(0, 1) != 0) ? CW'(n * 8 - $urandom_range(0, 7)) : CW'($urandom));
      add_random(n, 1'b1);
      tick();
      job_start = 1'b1;
      job_bswap = ~bs;
      tick();
      job_start = 1'b0;
      chk("restart_ignored_busy", job_busy, 1'b1);
      finish_job(n);
    end
    rand_full = 1'b0;

    // asynchronous reset in the middle of a job
    start_job(1'b0, 24'd48);
    add_random(6, 1'b1);
    wait_rx(2);
    #2;
    db = done_cnt;
    wb_rst_i = 1'b0;
    #1;
    check_reset_vals("abort");
    repeat (3) tick();
    wb_rst_i = 1'b1;
    repeat (2) tick();
    chk("no_done_after_abort", done_cnt - db, 0);

    // a clean job after the abort
    start_job(1'b1, 24'd32);
    add_random(4, 1'b1);
    finish_job(4);

    // byte-count check: 40 bytes needs 5 words, 32 bytes needs 4
    start_job(1'b0, 24'd40);
    add_random(4, 1'b1);
    finish_job(4);
    start_job(1'b0, 24'd32);
    add_random(4, 1'b1);
    finish_job(4);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
